// File: rtl/extref_pkg.sv
// Shared types and default constants for the ECP5 external reference clock monitor.
package extref_pkg;

    typedef enum logic [1:0] {
        OFF,
        SETTLE,
        MEASURE,
        LOCKED
    } ref_state_e;

    localparam int unsigned TOG_DIV     = 16;
    localparam int unsigned DEF_WINDOW  = 1000;
    localparam int unsigned DEF_EXP_MIN = 98;
    localparam int unsigned DEF_EXP_MAX = 102;

endpackage

// File: rtl/extref_chan.sv
// One reference channel: toggle synchroniser, saturating edge counter,
// power-up settle delay and lock/loss state machine.
module extref_chan
    import extref_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned EXP_MIN    = DEF_EXP_MIN,
    parameter int unsigned EXP_MAX    = DEF_EXP_MAX,
    parameter int unsigned LOCK_WINS  = 3,
    parameter int unsigned SETTLE_CYC = 256
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             tog_i,
    input  logic             win_end_i,
    output logic             pwdnb_o,
    output logic             locked_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned GW = $clog2(LOCK_WINS + 1);

    ref_state_e       state_q, state_d;
    logic [2:0]       sync_q;
    logic             tog_edge;
    logic [CNT_W-1:0] acc_q, acc_d, acc_inc;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [GW-1:0]    good_q, good_d;
    logic             armed_q, armed_d;
    logic [31:0]      cap32;
    logic             good;

    // sync_q[1] is the second synchroniser stage, sync_q[2] its history copy
    assign tog_edge = sync_q[1] ^ sync_q[2];
    assign acc_inc  = (tog_edge && (acc_q != '1)) ? acc_q + CNT_W'(1) : acc_q;
    assign cap32    = 32'(acc_inc);
    assign good     = (cap32 >= EXP_MIN) && (cap32 <= EXP_MAX);

    always_comb begin
        acc_d   = win_end_i ? '0 : acc_inc;
        count_d = win_end_i ? acc_inc : count_q;
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        good_d   = good_q;
        armed_d  = armed_q;
        if (!en_i) begin
            state_d  = OFF;
            settle_d = '0;
            good_d   = '0;
            armed_d  = 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d  = SETTLE;
                    settle_d = SW'(SETTLE_CYC - 1);
                end
                SETTLE: begin
                    if (settle_q == '0) begin
                        state_d = MEASURE;
                        good_d  = '0;
                        armed_d = 1'b0;
                    end else begin
                        settle_d = settle_q - SW'(1);
                    end
                end
                MEASURE: begin
                    // first window boundary after entry closes a partial window
                    if (win_end_i) begin
                        if (!armed_q) begin
                            armed_d = 1'b1;
                        end else if (good) begin
                            if (good_q == GW'(LOCK_WINS - 1)) begin
                                state_d = LOCKED;
                                good_d  = '0;
                            end else begin
                                good_d = good_q + GW'(1);
                            end
                        end else begin
                            good_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (win_end_i && !good) begin
                        state_d = MEASURE;
                        armed_d = 1'b1;
                        good_d  = '0;
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= OFF;
            sync_q   <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            settle_q <= '0;
            good_q   <= '0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[1:0], tog_i};
            acc_q    <= acc_d;
            count_q  <= count_d;
            settle_q <= settle_d;
            good_q   <= good_d;
            armed_q  <= armed_d;
        end
    end

    assign pwdnb_o  = (state_q != OFF);
    assign locked_o = (state_q == LOCKED);
    assign count_o  = count_q;

endmodule

// File: rtl/extref_monitor.sv
// Multi-channel EXTREF manager: shared measurement window timer, per-channel
// monitors and a non-revertive reference selector for the SerDes PLL mux.
module extref_monitor
    import extref_pkg::*;
#(
    parameter int unsigned NUM_REF    = 2,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned WINDOW     = DEF_WINDOW,
    parameter int unsigned EXP_MIN    = DEF_EXP_MIN,
    parameter int unsigned EXP_MAX    = DEF_EXP_MAX,
    parameter int unsigned LOCK_WINS  = 3,
    parameter int unsigned SETTLE_CYC = 256,
    parameter int unsigned SEL_W      = (NUM_REF > 1) ? $clog2(NUM_REF) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REF-1:0]       ref_en,
    input  logic [NUM_REF-1:0]       ref_tog,
    output logic [NUM_REF-1:0]       ref_pwdnb,
    output logic [NUM_REF-1:0]       ref_locked,
    output logic [NUM_REF*CNT_W-1:0] ref_count,
    output logic [SEL_W-1:0]         ref_sel,
    output logic                     ref_sel_valid,
    output logic                     switch_pulse
);

    localparam int unsigned TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic [TW-1:0]    timer_q, timer_d;
    logic             win_end;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             pulse_q, pulse_d;
    logic             sel_hit;
    logic             low_found;
    logic [SEL_W-1:0] low_idx;

    assign win_end = (timer_q == TW'(WINDOW - 1));
    assign timer_d = win_end ? '0 : timer_q + TW'(1);

    for (genvar g = 0; g < NUM_REF; g++) begin : g_chan
        extref_chan #(
            .CNT_W      (CNT_W),
            .EXP_MIN    (EXP_MIN),
            .EXP_MAX    (EXP_MAX),
            .LOCK_WINS  (LOCK_WINS),
            .SETTLE_CYC (SETTLE_CYC)
        ) u_chan (
            .clk_i     (clk),
            .rst_ni    (rst_n),
            .en_i      (ref_en[g]),
            .tog_i     (ref_tog[g]),
            .win_end_i (win_end),
            .pwdnb_o   (ref_pwdnb[g]),
            .locked_o  (ref_locked[g]),
            .count_o   (ref_count[g*CNT_W +: CNT_W])
        );
    end

    always_comb begin
        sel_hit   = 1'b0;
        low_found = 1'b0;
        low_idx   = '0;
        for (int unsigned i = 0; i < NUM_REF; i++) begin
            if ((SEL_W'(i) == sel_q) && ref_locked[i]) begin
                sel_hit = 1'b1;
            end
            if (!low_found && ref_locked[i]) begin
                low_found = 1'b1;
                low_idx   = SEL_W'(i);
            end
        end
        sel_d   = sel_q;
        valid_d = 1'b0;
        // stay on a still-locked reference even if a lower index recovers
        if (sel_hit) begin
            valid_d = 1'b1;
        end else if (low_found) begin
            sel_d   = low_idx;
            valid_d = 1'b1;
        end
        pulse_d = (sel_d != sel_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
        end
    end

    assign ref_sel       = sel_q;
    assign ref_sel_valid = valid_q;
    assign switch_pulse  = pulse_q;

endmodule

// File: tb/tb_extref_monitor.sv
// Self-checking bench for extref_monitor: timestamp-based edge model plus
// streak-based lock model, with a narrow-counter instance for saturation.
module tb_extref_monitor;

    localparam int NR = 2;
    localparam int unsigned W    = 200;
    localparam int unsigned SC   = 32;
    localparam int unsigned LW   = 3;
    localparam int unsigned EMIN = 18;
    localparam int unsigned EMAX = 22;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] ref_en;
    logic [NR-1:0] ref_tog;

    logic [NR-1:0]    pwdnb, locked;
    logic [NR*16-1:0] count;
    logic             sel, sel_valid, pulse;
    logic [NR-1:0]    pwdnb2, locked2;
    logic [NR*4-1:0]  count2;
    logic             sel2, sel_valid2, pulse2;

    always #4 clk = ~clk;

    extref_monitor #(
        .NUM_REF(NR), .CNT_W(16), .WINDOW(W), .EXP_MIN(EMIN), .EXP_MAX(EMAX),
        .LOCK_WINS(LW), .SETTLE_CYC(SC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ref_en(ref_en), .ref_tog(ref_tog),
        .ref_pwdnb(pwdnb), .ref_locked(locked), .ref_count(count),
        .ref_sel(sel), .ref_sel_valid(sel_valid), .switch_pulse(pulse)
    );

    extref_monitor #(
        .NUM_REF(NR), .CNT_W(4), .WINDOW(W), .EXP_MIN(EMIN), .EXP_MAX(EMAX),
        .LOCK_WINS(LW), .SETTLE_CYC(SC)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .ref_en(ref_en), .ref_tog(ref_tog),
        .ref_pwdnb(pwdnb2), .ref_locked(locked2), .ref_count(count2),
        .ref_sel(sel2), .ref_sel_valid(sel_valid2), .switch_pulse(pulse2)
    );

    int unsigned checks;
    int unsigned errors;

    // toggle generators
    int unsigned per [NR];
    int unsigned ph  [NR];
    bit          run [NR];
    bit          jit [NR];

    // reference model
    int unsigned cyc;
    int unsigned acc    [NR];
    int unsigned cnt    [NR];
    int unsigned streak [NR];
    int unsigned mode   [NR];   // 0 unpowered, 1 settling, 2 measuring
    int unsigned start  [NR];
    bit          armed  [NR];
    bit          last   [NR];
    bit          chg    [NR][4];
    bit [NR-1:0] mlock;
    int unsigned msel;
    bit          mvalid, mpulse;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v, input int unsigned m);
        return (v > m) ? m : v;
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int ch = 0; ch < NR; ch++) begin
            acc[ch] = 0; cnt[ch] = 0; streak[ch] = 0; mode[ch] = 0; start[ch] = 0;
            armed[ch] = 1'b0; last[ch] = 1'b0;
            for (int k = 0; k < 4; k++) chg[ch][k] = 1'b0;
        end
        mlock = '0; msel = 0; mvalid = 1'b0; mpulse = 1'b0;
    endtask

    task automatic model_posedge();
        bit [NR-1:0] newlock;
        int unsigned nsel;
        bit          nval;
        bit          e;
        bit          bnd;
        bit          good;
        cyc++;
        nsel = msel;
        nval = 1'b0;
        if (mlock[msel]) begin
            nval = 1'b1;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (!nval && mlock[i]) begin
                    nsel = i;
                    nval = 1'b1;
                end
            end
        end
        mpulse = (nsel != msel);
        msel   = nsel;
        mvalid = nval;
        bnd = (cyc % W == 0);
        for (int ch = 0; ch < NR; ch++) begin
            // a level change sampled at cycle m is counted two cycles later
            e = (cyc >= 3) ? chg[ch][(cyc - 2) % 4] : 1'b0;
            chg[ch][cyc % 4] = (ref_tog[ch] != last[ch]);
            last[ch] = ref_tog[ch];
            if (bnd) begin
                cnt[ch] = acc[ch] + e;
                acc[ch] = 0;
            end else begin
                acc[ch] = acc[ch] + e;
            end
            good = (cnt[ch] >= EMIN) && (cnt[ch] <= EMAX);
            if (!ref_en[ch]) begin
                mode[ch] = 0; streak[ch] = 0; armed[ch] = 1'b0;
            end else if (mode[ch] == 0) begin
                mode[ch] = 1; start[ch] = cyc;
            end else if (mode[ch] == 1) begin
                if (cyc - start[ch] == SC) begin
                    mode[ch] = 2; streak[ch] = 0; armed[ch] = 1'b0;
                end
            end else if (bnd) begin
                if (!armed[ch]) armed[ch] = 1'b1;
                else streak[ch] = good ? streak[ch] + 1 : 0;
            end
            newlock[ch] = (mode[ch] == 2) && (streak[ch] >= LW);
        end
        mlock = newlock;
    endtask

    task automatic check_all();
        logic [NR-1:0]    epw;
        logic [NR*16-1:0] ec;
        logic [NR*4-1:0]  ec2;
        for (int ch = 0; ch < NR; ch++) begin
            epw[ch] = (mode[ch] != 0);
            ec[ch*16 +: 16] = 16'(sat(cnt[ch], 65535));
            ec2[ch*4 +: 4]  = 4'(sat(cnt[ch], 15));
        end
        chk("pwdnb",      64'(pwdnb),      64'(epw));
        chk("locked",     64'(locked),     64'(mlock));
        chk("count",      64'(count),      64'(ec));
        chk("sel",        64'(sel),        64'(msel));
        chk("sel_valid",  64'(sel_valid),  64'(mvalid));
        chk("pulse",      64'(pulse),      64'(mpulse));
        chk("sat_count",  64'(count2),     64'(ec2));
        chk("sat_pwdnb",  64'(pwdnb2),     64'(epw));
        chk("sat_locked", 64'(locked2),    64'(0));
        chk("sat_sel",    64'({sel2, sel_valid2, pulse2}), 64'(0));
    endtask

    task automatic drive_tog();
        for (int ch = 0; ch < NR; ch++) begin
            if (run[ch]) begin
                if (ph[ch] == 0) begin
                    ref_tog[ch] = ~ref_tog[ch];
                    ph[ch] = per[ch] - 1;
                    if (jit[ch]) ph[ch] = ph[ch] - 1 + $urandom_range(0, 2);
                end else begin
                    ph[ch] = ph[ch] - 1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_posedge();
        @(negedge clk);
        check_all();
        drive_tog();
    endtask

    task automatic run_cycles(input int unsigned n);
        repeat (n) step();
    endtask

    task automatic to_boundary();
        do step(); while (cyc % W != 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dut"}, 64'({pwdnb, locked, count, sel, sel_valid, pulse}), 64'(0));
        chk({tag, "_sat"}, 64'({pwdnb2, locked2, count2, sel2, sel_valid2, pulse2}), 64'(0));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n   = 1'b0;
        ref_en  = '0;
        ref_tog = '0;
        for (int ch = 0; ch < NR; ch++) begin
            per[ch] = 10; ph[ch] = 0; run[ch] = 1'b0; jit[ch] = 1'b0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n  = 1'b1;
        ref_en = 2'b11;
        run[0] = 1'b1;
        run[1] = 1'b1;

        // both references nominal: lock after settle, partial window and three goods
        repeat (5) to_boundary();
        chk("p1_locked", 64'(locked), 64'(2'b11));
        chk("p1_sel", 64'({sel, sel_valid}), 64'(2'b01));
        chk("p1_count", 64'(count), 64'(32'h0014_0014));
        chk("p1_sat", 64'(count2), 64'(8'hFF));

        // ch0 toggle stops: loss, failover to ch1
        run[0] = 1'b0;
        repeat (2) to_boundary();
        chk("p2_locked", 64'(locked), 64'(2'b10));
        chk("p2_sel", 64'({sel, sel_valid}), 64'(2'b11));
        chk("p2_count0", 64'(count[15:0]), 64'(0));

        // ch0 restored: relocks but selection does not revert
        run[0] = 1'b1;
        repeat (5) to_boundary();
        chk("p3_locked", 64'(locked), 64'(2'b11));
        chk("p3_sel", 64'(sel), 64'(1));

        // ch0 off frequency (25 edges per window)
        per[0] = 8;
        repeat (4) to_boundary();
        chk("p4_locked0", 64'(locked[0]), 64'(0));
        chk("p4_count0", 64'(count[15:0]), 64'(25));
        chk("p4_sel", 64'(sel), 64'(1));

        // good, bad, good, good, good on ch0
        per[0] = 10; to_boundary(); chk("gb_g1", 64'(locked[0]), 64'(0));
        per[0] = 8;  to_boundary(); chk("gb_b",  64'(locked[0]), 64'(0));
        per[0] = 10; to_boundary(); chk("gb_g2", 64'(locked[0]), 64'(0));
        to_boundary(); chk("gb_g3", 64'(locked[0]), 64'(0));
        to_boundary(); chk("gb_g4", 64'(locked[0]), 64'(1));

        // move selection to ch0, bring ch1 back, then disable ch0 and ch1
        ref_en[1] = 1'b0;
        run_cycles(3);
        chk("p6_sel0", 64'({sel, sel_valid}), 64'(2'b01));
        ref_en[1] = 1'b1;
        repeat (5) to_boundary();
        chk("p6_locked", 64'(locked), 64'(2'b11));
        chk("p6_hold0", 64'(sel), 64'(0));
        ref_en[0] = 1'b0;
        step();
        chk("p6_off0", 64'({pwdnb[0], locked[0]}), 64'(0));
        run_cycles(2);
        chk("p6_fail1", 64'({sel, sel_valid}), 64'(2'b11));
        ref_en[1] = 1'b0;
        run_cycles(3);
        chk("p6_none", 64'({sel, sel_valid}), 64'(2'b10));

        // randomized rates, jitter, enables and gaps
        for (int r = 0; r < 10; r++) begin
            for (int ch = 0; ch < NR; ch++) begin
                per[ch] = $urandom_range(8, 12);
                jit[ch] = 1'b1;
                run[ch] = ($urandom_range(0, 7) != 0);
            end
            ref_en = 2'($urandom_range(1, 3));
            run_cycles($urandom_range(W, 3 * W));
        end

        // asynchronous reset in mid-window, then a clean relock from timer 0
        for (int ch = 0; ch < NR; ch++) begin
            per[ch] = 10; jit[ch] = 1'b0; run[ch] = 1'b1;
        end
        ref_en = 2'b11;
        run_cycles(W + 77);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (5) to_boundary();
        chk("p8_locked", 64'(locked), 64'(2'b11));
        chk("p8_sel", 64'({sel, sel_valid}), 64'(2'b01));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
